// File: rtl/core_cmd_issuer_pkg.sv
// Shared types for the command issuer: opcodes, FSM states, queued command
// layout and default sizing.
package core_cmd_issuer_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4,
    OP_RD  = 3'd5,
    OP_WR  = 3'd6,
    OP_RB3 = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT    = 64;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // One queued command as stored in the FIFO.
  typedef struct packed {
    opcode_t     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] addr;
    logic [7:0]  data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Width of the WAIT-phase cycle counter; at least one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/core_cmd_issuer_if.sv
// Bundle of the command, core and response channels of the issuer.
// slave: the issuer itself; master: the surrounding environment.
interface core_cmd_issuer_if;
  import core_cmd_issuer_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  opcode_t     cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_data;

  logic [7:0]  A;
  logic [7:0]  B;
  opcode_t     op_sel;
  logic [11:0] address_in;
  logic [7:0]  data_in;
  logic        start_op;
  logic        end_op;
  logic [15:0] result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  opcode_t     rsp_op;
  logic        rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_addr, cmd_data,
    output cmd_ready,
    output A, B, op_sel, address_in, data_in, start_op,
    input  end_op, result,
    output rsp_valid, rsp_result, rsp_op, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_addr, cmd_data,
    input  cmd_ready,
    input  A, B, op_sel, address_in, data_in, start_op,
    output end_op, result,
    input  rsp_valid, rsp_result, rsp_op, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/core_cmd_issuer_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrap-bit pointers, head entry visible
// combinationally on dout. Pushes while full and pops while empty are dropped.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      used_s;

  assign used_s = wr_ptr_r - rd_ptr_r;
  assign full   = (used_s == (AW+1)'(DEPTH));
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Entry storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/core_cmd_issuer.sv
// Command issuer: queues commands, issues them one at a time to the core with
// a single start_op pulse, waits for end_op (bounded by TIMEOUT) and returns
// the result or a timeout error through a valid/ready response port.
module core_cmd_issuer
  import core_cmd_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  core_cmd_issuer_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  cmd_t             cmd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             start_op_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [15:0]      rsp_result_r;
  opcode_t          rsp_op_r;

  cmd_t             fifo_din_s;
  logic [CMD_W-1:0] fifo_dout_raw_s;
  cmd_t             fifo_dout_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  assign fifo_din_s  = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b,
                         addr: bus.cmd_addr, data: bus.cmd_data};
  assign fifo_dout_s = cmd_t'(fifo_dout_raw_s);
  // A pop in the same cycle does not reopen a full FIFO to the requester.
  assign push_s      = bus.cmd_valid && !full_s;
  assign pop_s       = (state_r == ST_IDLE) && !empty_s;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_raw_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue FSM with operand registers, WAIT counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cmd_r        <= cmd_t'({CMD_W{1'b0}});
      cnt_r        <= {CNT_W{1'b0}};
      start_op_r   <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_result_r <= 16'h0000;
      rsp_op_r     <= OP_NOP;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            cmd_r      <= fifo_dout_s;
            start_op_r <= 1'b1;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_op_r <= 1'b0;
          cnt_r      <= {CNT_W{1'b0}};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the last allowed cycle still wins over timeout.
          if (bus.end_op) begin
            rsp_result_r <= bus.result;
            rsp_err_r    <= 1'b0;
            rsp_op_r     <= cmd_r.op;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            rsp_result_r <= 16'h0000;
            rsp_err_r    <= 1'b1;
            rsp_op_r     <= cmd_r.op;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          start_op_r  <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = !full_s;
  assign bus.A          = cmd_r.a;
  assign bus.B          = cmd_r.b;
  assign bus.op_sel     = cmd_r.op;
  assign bus.address_in = cmd_r.addr;
  assign bus.data_in    = cmd_r.data;
  assign bus.start_op   = start_op_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_op     = rsp_op_r;
  assign bus.rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_core_cmd_issuer.sv
// Self-checking bench for core_cmd_issuer: vector table through a scoreboard,
// a behavioural core that answers start_op after a per-command latency, and
// hand-written sequences for backpressure, spurious strobes, a short timeout
// and reset mid-operation.
module tb_core_cmd_issuer;
  import core_cmd_issuer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_cmd_issuer_if bus ();
  core_cmd_issuer_if bus8 ();

  core_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut  (.clk(clk), .rst(rst), .bus(bus));
  core_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    opcode_t     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] addr;
    logic [7:0]  data;
  } issue_t;

  typedef struct {
    logic [15:0] result;
    opcode_t     op;
    logic        err;
  } rsp_t;

  // lat = cycles from start_op to end_op; 0 = core never answers.
  typedef struct {
    opcode_t     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] addr;
    logic [7:0]  data;
    int          lat;
    logic [15:0] exp_res;
    logic        exp_err;
  } vec_t;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     last_start = -100;
  logic   spur_req = 1'b0;
  issue_t issue_q[$];
  rsp_t   exp_q[$];
  int     lat_q[$];
  vec_t   vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural core plus issue-order / pulse-spacing monitor.
  initial begin
    int pend;
    issue_t e;
    pend = 0;
    bus.end_op = 1'b0;
    bus.result = 16'h0000;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.end_op = 1'b0;
      if (rst) pend = 0;
      if (spur_req) begin
        bus.end_op = 1'b1;
        bus.result = 16'hDEAD;
        spur_req   = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.end_op = 1'b1;
          bus.result = {8'h00, bus.A} + {8'h00, bus.B};
        end
      end
      if (bus.start_op) begin
        chk("start_gap_ge4", 32'(cyc - last_start >= 4), 32'd1);
        last_start = cyc;
        chk("start_has_cmd", 32'(issue_q.size() > 0), 32'd1);
        if (issue_q.size() > 0) begin
          e = issue_q.pop_front();
          chk("issue_op",   32'(bus.op_sel),     32'(e.op));
          chk("issue_a",    32'(bus.A),          32'(e.a));
          chk("issue_b",    32'(bus.B),          32'(e.b));
          chk("issue_addr", 32'(bus.address_in), 32'(e.addr));
          chk("issue_data", 32'(bus.data_in),    32'(e.data));
        end
        pend = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end
    end
  end

  // Response scoreboard: compare each handshaken response with the queue head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_result", 32'(bus.rsp_result), 32'(e.result));
          chk("rsp_op",     32'(bus.rsp_op),     32'(e.op));
          chk("rsp_err",    32'(bus.rsp_err),    32'(e.err));
        end
      end
    end
  end

  task automatic push_cmd(input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic [11:0] addr, input logic [7:0] data, input int lat,
                          input logic [15:0] exp_res, input logic exp_err);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("push_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    issue_q.push_back('{op, a, b, addr, data});
    exp_q.push_back('{exp_res, op, exp_err});
    lat_q.push_back(lat);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int starts;
    int valids;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.cmd_addr = 12'h000; bus.cmd_data = 8'h00; bus.rsp_ready = 1'b1;
    bus8.cmd_valid = 1'b0; bus8.cmd_op = OP_NOP; bus8.cmd_a = 8'h00; bus8.cmd_b = 8'h00;
    bus8.cmd_addr = 12'h000; bus8.cmd_data = 8'h00; bus8.rsp_ready = 1'b1;
    bus8.end_op = 1'b0; bus8.result = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_start_op",   32'(bus.start_op),   32'd0);
    chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_A",          32'(bus.A),          32'd0);
    chk("rst_B",          32'(bus.B),          32'd0);
    chk("rst_address_in", 32'(bus.address_in), 32'd0);
    chk("rst_data_in",    32'(bus.data_in),    32'd0);
    chk("rst_op_sel",     32'(bus.op_sel),     32'(OP_NOP));
    chk("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);

    // Vector table; core result is A+B
    vecs[0] = '{OP_RB3, 8'hFF, 8'hFE, 12'h123, 8'h5A, 3,  16'h01FD, 1'b0};
    vecs[1] = '{OP_ADD, 8'h01, 8'h02, 12'h000, 8'h00, 1,  16'h0003, 1'b0};
    vecs[2] = '{OP_XOR, 8'h80, 8'h80, 12'hFFF, 8'hFF, 2,  16'h0100, 1'b0};
    vecs[3] = '{OP_MUL, 8'h10, 8'h20, 12'hABC, 8'h11, 64, 16'h0030, 1'b0};
    vecs[4] = '{OP_AND, 8'h12, 8'h34, 12'h456, 8'h78, 0,  16'h0000, 1'b1};
    vecs[5] = '{OP_RD,  8'h7F, 8'h01, 12'h001, 8'h80, 65, 16'h0000, 1'b1};
    vecs[6] = '{OP_WR,  8'hAA, 8'h55, 12'h800, 8'h3C, 5,  16'h00FF, 1'b0};
    for (int i = 0; i < 7; i++) begin
      push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].data,
               vecs[i].lat, vecs[i].exp_res, vecs[i].exp_err);
    end
    wait_drain(1500);

    // Backpressure: response held for 10 cycles, then FIFO filled behind it
    bus.rsp_ready = 1'b0;
    push_cmd(OP_ADD, 8'h05, 8'h06, 12'h010, 8'h01, 2, 16'h000B, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid",  32'(bus.rsp_valid),  32'd1);
      chk("hold_result", 32'(bus.rsp_result), 32'h000B);
      chk("hold_op",     32'(bus.rsp_op),     32'(OP_ADD));
      chk("hold_err",    32'(bus.rsp_err),    32'd0);
      chk("hold_no_start", 32'(bus.start_op), 32'd0);
      @(posedge clk); #1;
    end
    push_cmd(OP_RD,  8'h10, 8'h01, 12'h100, 8'h01, 1, 16'h0011, 1'b0);
    push_cmd(OP_WR,  8'h20, 8'h02, 12'h200, 8'h02, 2, 16'h0022, 1'b0);
    push_cmd(OP_AND, 8'h30, 8'h03, 12'h300, 8'h03, 1, 16'h0033, 1'b0);
    push_cmd(OP_RB3, 8'h40, 8'h04, 12'h400, 8'h04, 3, 16'h0044, 1'b0);
    chk("full_after_4", 32'(bus.cmd_ready), 32'd0);
    chk("full_still_resp", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_low_on_pop", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_pop", 32'(bus.cmd_ready), 32'd1);
    wait_drain(300);

    // Spurious end_op while idle must not leak into the next response
    spur_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    push_cmd(OP_XOR, 8'h21, 8'h43, 12'h055, 8'h66, 2, 16'h0064, 1'b0);
    wait_drain(100);

    // TIMEOUT=8 instance: no end_op, response 8 cycles after WAIT entry
    bus8.cmd_valid = 1'b1; bus8.cmd_op = OP_MUL; bus8.cmd_a = 8'h09; bus8.cmd_b = 8'h07;
    bus8.cmd_addr = 12'h321; bus8.cmd_data = 8'h44;
    @(posedge clk); #1;
    bus8.cmd_valid = 1'b0;
    n = 0;
    while (!bus8.start_op && n < 10) begin @(posedge clk); #1; n++; end
    chk("to8_start_seen", 32'(bus8.start_op), 32'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus8.rsp_valid && n < 40);
    // n counts from the ISSUE cycle: 1 ISSUE + 8 WAIT cycles
    chk("to8_latency", 32'(n), 32'd9);
    chk("to8_err",     32'(bus8.rsp_err),    32'd1);
    chk("to8_result",  32'(bus8.rsp_result), 32'd0);
    chk("to8_op",      32'(bus8.rsp_op),     32'(OP_MUL));
    @(posedge clk); #1;

    // Reset during WAIT with two commands queued
    push_cmd(OP_ADD, 8'h01, 8'h01, 12'h001, 8'h01, 0, 16'h0000, 1'b1);
    push_cmd(OP_AND, 8'h02, 8'h02, 12'h002, 8'h02, 0, 16'h0000, 1'b1);
    push_cmd(OP_XOR, 8'h03, 8'h03, 12'h003, 8'h03, 0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    issue_q.delete();
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mrst_start_op",  32'(bus.start_op),  32'd0);
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_A",         32'(bus.A),         32'd0);
    starts = 0;
    valids = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.start_op)  starts++;
      if (bus.rsp_valid) valids++;
    end
    chk("mrst_no_start", 32'(starts), 32'd0);
    chk("mrst_no_rsp",   32'(valids), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
